ita_softmax_div: RTL

- Single-lane iterative reciprocal divider fed by the softmax division FIFO.
- Computes quotient = floor(2^NumShift / divisor), where the divisor is the accumulated exponent sum of a row.
- Returns the normalisation factor that the softmax unit writes back to its accumulator memory.
- NumDiv instances sit in parallel; the softmax stage round-robins valid/ready across them.

---
 rtl/ita_softmax_div.sv | 116 +++++++++++
 1 files changed

// File: rtl/ita_softmax_div.sv
// Iterative restoring reciprocal divider: quot_o = sat(floor(2^NumShift / div_inp_i)).
// Optional ITA_DIV_POW2_BYPASS_EN resolves power-of-two divisors without iterating.
module ita_softmax_div #(
    parameter int unsigned InWidth  = 19,
    parameter int unsigned OutWidth = 16,
    parameter int unsigned NumShift = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [InWidth-1:0]  div_inp_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic [OutWidth-1:0] quot_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                busy_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int unsigned CntW  = $clog2(NumShift + 2);
    localparam int unsigned WideW = (NumShift + 1 > OutWidth) ? NumShift + 1 : OutWidth;

    logic [1:0]          state_q;
    logic [InWidth-1:0]  div_q;
    logic [InWidth:0]    rem_q;
    logic [NumShift:0]   quo_q;
    logic [CntW-1:0]     cnt_q;

    logic                nbit;
    logic [InWidth+1:0]  rem_sh;
    logic [InWidth+1:0]  div_ext;
    logic                take;

    function automatic logic [OutWidth-1:0] saturate(input logic [NumShift:0] q);
        logic [WideW-1:0] qw;
        logic [WideW-1:0] lim;
        qw  = WideW'(q);
        lim = WideW'({OutWidth{1'b1}});
        return (qw > lim) ? {OutWidth{1'b1}} : qw[OutWidth-1:0];
    endfunction

`ifdef ITA_DIV_POW2_BYPASS_EN
    function automatic logic is_pow2(input logic [InWidth-1:0] d);
        return (d != '0) && ((d & (d - InWidth'(1))) == '0);
    endfunction

    // 2^NumShift / 2^k is a plain right shift; k > NumShift shifts the bit out to zero.
    function automatic logic [NumShift:0] pow2_quot(input logic [InWidth-1:0] d);
        logic [NumShift:0] q;
        q = '0;
        for (int k = 0; k < int'(InWidth); k++) begin
            if (d[k]) q = {1'b1, {NumShift{1'b0}}} >> k;
        end
        return q;
    endfunction
`endif

    // Numerator is 2^NumShift: only the first step shifts in a one.
    assign nbit    = (cnt_q == CntW'(NumShift + 1));
    assign rem_sh  = {rem_q, nbit};
    assign div_ext = (InWidth + 2)'(div_q);
    assign take    = (rem_sh >= div_ext);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            div_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        div_q <= div_inp_i;
                        rem_q <= '0;
                        quo_q <= '0;
                        cnt_q <= CntW'(NumShift + 1);
                        if (div_inp_i == '0) begin
                            quo_q   <= '1;
                            state_q <= DONE;
                        end
`ifdef ITA_DIV_POW2_BYPASS_EN
                        else if (is_pow2(div_inp_i)) begin
                            quo_q   <= pow2_quot(div_inp_i);
                            state_q <= DONE;
                        end
`endif
                        else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= (InWidth + 1)'(take ? (rem_sh - div_ext) : rem_sh);
                    quo_q <= {quo_q[NumShift-1:0], take};
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) state_q <= DONE;
                end
                DONE: begin
                    if (ready_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign busy_o  = (state_q != IDLE);
    assign quot_o  = valid_o ? saturate(quo_q) : '0;

endmodule
